// File: rtl/sum_mult_arbiter_pkg.sv
// Shared constants and helpers for the sum-product arbiter slice.
// Defaults match the standard four-requester, 3-bit-operand configuration.
package sum_mult_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 3;
  localparam int SUM_W       = DEF_DATA_W + 1;
  localparam int PROD_W      = 2 * SUM_W;
  localparam int PTR_W       = $clog2(DEF_NUM_REQ);

  typedef logic [PTR_W-1:0] ptr_t;

  // Position of the k-th candidate in a round-robin scan that starts at base.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction
endpackage

// File: rtl/sum_mult_arbiter_if.sv
// Request/response bundle between the requesting units and the shared datapath.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// initiator keeps valid and its payload stable until that edge, and ready may
// depend combinationally on valid.
interface sum_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_c;
  logic [NUM_REQ*DATA_W-1:0] req_d;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [2*DATA_W+1:0]       rsp_y;

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/sum_mult_arbiter_stage.sv
// Two-register (a+b)*(c+d) datapath: stage 1 holds the sums, stage 2 the product.
// Both stages move only when en is high; the id tag travels with the data.
module sum_mult_stage
  import sum_mult_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = PTR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                in_valid,
  input  logic [ID_W-1:0]     in_id,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [DATA_W-1:0]   in_c,
  input  logic [DATA_W-1:0]   in_d,
  output logic                s1_valid,
  output logic                out_valid,
  output logic [ID_W-1:0]     out_id,
  output logic [2*DATA_W+1:0] out_y
);
  localparam int SW = DATA_W + 1;
  localparam int PW = 2 * SW;

  logic [SW-1:0]   sum0;
  logic [SW-1:0]   sum1;
  logic [ID_W-1:0] s1_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      sum0      <= '0;
      sum1      <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_y     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        sum0  <= SW'(in_a) + SW'(in_b);
        sum1  <= SW'(in_c) + SW'(in_d);
        s1_id <= in_id;
      end
      // Result registers keep the last delivered value once valid drops.
      if (s1_valid) begin
        out_y  <= PW'(sum0) * PW'(sum1);
        out_id <= s1_id;
      end
    end
  end
endmodule

// File: rtl/sum_mult_arbiter.sv
// Round-robin front end sharing one sum-product pipeline among NUM_REQ requesters.
// Results return tagged with the requester index on a single backpressured port.
module sum_mult_arbiter
  import sum_mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic            clock,
  input  logic            reset,
  sum_mult_arbiter_if.slave bus,
  output logic            busy,
  output logic [ID_W-1:0] dbg_ptr
);
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               adv;
  logic               accept;
  logic               s1_valid;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [DATA_W-1:0] c_arr [NUM_REQ];
  logic [DATA_W-1:0] d_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*DATA_W +: DATA_W];
    assign b_arr[g] = bus.req_b[g*DATA_W +: DATA_W];
    assign c_arr[g] = bus.req_c[g*DATA_W +: DATA_W];
    assign d_arr[g] = bus.req_d[g*DATA_W +: DATA_W];
  end

  // The whole pipeline moves together; a stalled result freezes everything.
  assign adv = !bus.rsp_valid || bus.rsp_ready;

  always_comb begin
    grant = '0;
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'(rr_index(int'(ptr), k, NUM_REQ));
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

  assign bus.req_ready = (adv && !reset) ? grant : '0;
  assign accept        = |bus.req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
    end
  end

  sum_mult_stage #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_stage (
    .clock     (clock),
    .reset     (reset),
    .en        (adv),
    .in_valid  (accept),
    .in_id     (gid),
    .in_a      (a_arr[gid]),
    .in_b      (b_arr[gid]),
    .in_c      (c_arr[gid]),
    .in_d      (d_arr[gid]),
    .s1_valid  (s1_valid),
    .out_valid (bus.rsp_valid),
    .out_id    (bus.rsp_id),
    .out_y     (bus.rsp_y)
  );

  assign busy    = s1_valid || bus.rsp_valid;
  assign dbg_ptr = ptr;
endmodule

// File: tb/tb_sum_mult_arbiter.sv
// Directed bench for sum_mult_arbiter: accepts push hand-computed results into a
// queue, a separate monitor pops and compares every delivered response.
module tb_sum_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 3;
  localparam int ID_W    = 2;
  localparam int Y_W     = 2 * DATA_W + 2;

  logic            clock;
  logic            reset;
  logic            busy;
  logic [ID_W-1:0] dbg_ptr;

  sum_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  sum_mult_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  logic [ID_W+Y_W-1:0] exp_q[$];
  logic [ID_W-1:0]     exp_grant_q[$];
  logic [Y_W-1:0]      exp_y [NUM_REQ];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d, input logic [7:0] y);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_c[i*DATA_W +: DATA_W] = c;
    bus.req_d[i*DATA_W +: DATA_W] = d;
    exp_y[i] = y;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Raise the requests in mask and wait for n accepts; with keep=0 each
  // requester drops its valid once served.
  task automatic run_accepts(input logic [NUM_REQ-1:0] mask, input int n, input bit keep,
                             output int cycles);
    logic [NUM_REQ-1:0] got;
    int acc;
    acc = 0;
    cycles = 0;
    bus.req_valid = mask;
    while (acc < n && cycles < 100) begin
      @(negedge clock);
      cycles++;
      got = bus.req_valid & bus.req_ready;
      if (got != '0) acc++;
      tick();
      if (!keep) bus.req_valid = bus.req_valid & ~got;
    end
    bus.req_valid = '0;
    check("accept_count", acc, n);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- accept monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("ready_onehot_valid",
            {31'b0, $onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)}, 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back({ID_W'(i), exp_y[i]});
          if (exp_grant_q.size() > 0) check("grant_order", i, exp_grant_q.pop_front());
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clock) begin
    logic [ID_W+Y_W-1:0] e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", bus.rsp_id, e[ID_W+Y_W-1:Y_W]);
        check("rsp_y", bus.rsp_y, e[Y_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    reset = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.req_d = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_y[i] = '0;
    tick();
    tick();
    @(negedge clock);
    check("ready_in_reset", bus.req_ready, 0);
    tick();
    reset = 1'b0;
    bus.req_valid = '0;
    @(negedge clock);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ptr", dbg_ptr, 0);

    // Single request: (1+2)*(3+4) = 21, two edges of latency.
    tick();
    set_op(0, 3'd1, 3'd2, 3'd3, 3'd4, 8'd21);
    bus.req_valid = 4'b0001;
    @(negedge clock);
    check("single_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    check("lat_stage1_rsp_valid", bus.rsp_valid, 0);
    check("lat_stage1_busy", busy, 1);
    @(negedge clock);
    check("lat_rsp_valid", bus.rsp_valid, 1);
    tick();
    drain();

    // All four requesting back to back; req3 carries the maximum operands.
    do_reset();
    set_op(0, 3'd1, 3'd1, 3'd1, 3'd1, 8'd4);
    set_op(1, 3'd2, 3'd0, 3'd1, 3'd2, 8'd6);
    set_op(2, 3'd3, 3'd4, 3'd0, 3'd5, 8'd35);
    set_op(3, 3'd7, 3'd7, 3'd7, 3'd7, 8'd196);
    exp_grant_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    run_accepts(4'b1111, 5, 1'b1, cyc);
    check("b2b_cycles", cyc, 5);
    drain();
    check("ptr_after_rr", dbg_ptr, 1);

    // Backpressure: one result pending, one in stage 1, a third requester waiting.
    bus.rsp_ready = 1'b0;
    set_op(0, 3'd5, 3'd6, 3'd1, 3'd0, 8'd11);
    set_op(1, 3'd2, 3'd3, 3'd4, 3'd4, 8'd40);
    set_op(2, 3'd1, 3'd1, 3'd1, 3'd1, 8'd4);
    run_accepts(4'b0001, 1, 1'b0, cyc);
    run_accepts(4'b0010, 1, 1'b0, cyc);
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_ready", bus.req_ready, 0);
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_rsp_y", bus.rsp_y, 11);
      check("stall_rsp_id", bus.rsp_id, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    run_accepts(4'b0100, 1, 1'b0, cyc);
    drain();

    // Wrap-around: with ptr=2, req2 goes before req1.
    do_reset();
    run_accepts(4'b0010, 1, 1'b0, cyc);
    drain();
    @(negedge clock);
    check("ptr_before_wrap", dbg_ptr, 2);
    tick();
    exp_grant_q = '{2'd2, 2'd1};
    run_accepts(4'b0110, 2, 1'b0, cyc);
    drain();

    // Reset with two operations in flight discards both.
    bus.rsp_ready = 1'b0;
    set_op(3, 3'd7, 3'd7, 3'd7, 3'd7, 8'd196);
    run_accepts(4'b1000, 1, 1'b0, cyc);
    run_accepts(4'b0001, 1, 1'b0, cyc);
    @(negedge clock);
    check("inflight_busy", busy, 1);
    check("max_rsp_y", bus.rsp_y, 196);
    check("max_rsp_id", bus.rsp_id, 3);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    check("flush_rsp_valid", bus.rsp_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_ptr", dbg_ptr, 0);
    tick();
    exp_grant_q = '{2'd1, 2'd3};
    run_accepts(4'b1010, 2, 1'b0, cyc);
    drain();
    check("grant_queue_empty", exp_grant_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
